tart_hilbert_tmux: RTL and testbench
====================================

Name: tart_hilbert_tmux

Overview:
Front end of the correlator path. It samples the 24-bit raw antenna word once per TRATE fast-clock cycles. It produces the real/imaginary pair by a one-sample-delay Hilbert approximation: im is the previous sample and re is the current sample. It also generates the `valid`/`strobe` timing that drives the RMW address unit and the correlators at 12:1 time-multiplexing.

Parameters:
- WIDTH, 24 (`NUM_ANTENNA`): number of antenna bits per sample.
- TRATE, 12 (`TMUX_RATE`): fast-clock cycles per antenna sample.
- TBITS, 4: bit-width of the time-multiplex counter; must satisfy 2^TBITS >= TRATE.
- DELAY, 3: simulation-only non-blocking assignment delay in ns.

Ports:
- clk_x  in  1  fast correlator clock, TRATE x sample rate; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  acquisition enable, already synchronised to clk_x.
- d_i  in  WIDTH  raw antenna sample, stable across each TRATE window.
- valid_o  out  1  re_o/im_o are valid; acts as the correlator clock-enable.
- strobe_o  out  1  one-cycle pulse, registered together with each new re_o/im_o pair.
- re_o  out  WIDTH  current sample.
- im_o  out  WIDTH  previous sample.
- tick_o  out  TBITS  current TMUX counter value, for debug.

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, cnt=0, valid_o=0, strobe_o=0, re_o=0, im_o=0, tick_o=0. Reset has priority over every other event.
- Counter cnt:
  - Forced to 0 whenever en_i=0.
  - While en_i=1, increments every cycle, wrapping TRATE-1 -> 0.
  - tick = en_i && cnt==TRATE-1 (combinational).
- State machine with states IDLE, PRIME, RUN:
  - IDLE: outputs valid_o=0, strobe_o=0; re_o/im_o hold. If en_i=1 -> PRIME.
  - PRIME: on tick, capture d_i into re_o and go to RUN; no strobe, valid_o stays 0.
  - RUN: on tick, im_o<=re_o, re_o<=d_i, strobe_o<=1, valid_o<=1. On non-tick cycles strobe_o<=0 and valid_o holds.
  - In any state, en_i=0 -> IDLE next edge, with valid_o<=0 and strobe_o<=0. re_o/im_o keep their last values.
- Latency: en_i first sampled high at edge k.
  - cnt=0 after edge k.
  - Prime capture at edge k+12.
  - First strobe_o/valid_o rise after edge k+24.
  - Subsequent strobes every 12 cycles (edges k+36, k+48, ...).
- valid_o stays 1 continuously in RUN, so the correlator's RMW unit advances every cycle. strobe_o marks TMUX slot 0.
- Simultaneous en_i fall and tick: en_i=0 wins; no capture, no strobe.
- en_i re-asserted after a drop: full re-prime, so the first strobe again comes 24 cycles later. A stale im_o is never paired with a fresh re_o.
- rst_i mid-RUN: all outputs zero next edge. Resume requires en_i high and a full re-prime.
- Width rule: re_o/im_o are exact bit copies; no arithmetic. cnt never exceeds TRATE-1.

Decomposition:
- Shared package / tartcfg: NUM_ANTENNA, TMUX_RATE, TBITS, and the state encoding localparams (IDLE=2'b00, PRIME=2'b01, RUN=2'b10).
- One sub-module: tmux_sequencer, holding the cnt counter plus tick generation and exposing clk_x, rst_i, en_i, tick, cnt. It is reusable by other TMUX stages.
- Data registers and the FSM stay in the top.

Test Plan:
1. Assert rst_i for 3 cycles with en_i=1 and d_i=24'hFFFFFF -> all outputs 0 and state IDLE throughout reset.
2. Raise en_i at edge k and present d_i=24'h000001, then 24'h000002, then 24'h000003, each held for 12 cycles -> after edge k+24: re_o=24'h000002, im_o=24'h000001, strobe_o=1 for exactly one cycle, valid_o=1. After edge k+36: re_o=24'h000003, im_o=24'h000002.
3. Steady RUN for 10 samples -> exactly 10 strobe_o pulses, spaced exactly 12 cycles apart; valid_o never drops.
4. Drop en_i on the cycle with cnt=11 -> no capture and no strobe. valid_o=0 next edge. re_o/im_o keep their previous values.
5. Re-raise en_i 5 cycles later with d_i=24'hABCDEF, then 24'h123456 -> first strobe 24 cycles after re-enable, with re_o=24'h123456 and im_o=24'hABCDEF (not the pre-drop sample).
6. Pulse rst_i for 1 cycle mid-RUN with en_i held high -> outputs zero next edge. The next strobe comes 24 cycles after rst_i deasserts.

Source files
------------

// File: rtl/tart_hilbert_tmux_pkg.sv
// Shared configuration for the TART correlator front end.
// Holds the antenna width, the time-multiplex rate, the counter width and
// the front-end state encoding. Other files import it with
// import tart_hilbert_tmux_pkg::*.
package tart_hilbert_tmux_pkg;

  localparam int NUM_ANTENNA = 24;
  localparam int TMUX_RATE   = 12;
  localparam int TBITS       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRIME = 2'b01,
    ST_RUN   = 2'b10
  } tmux_state_e;

endpackage

// File: rtl/tart_hilbert_tmux_tmux_sequencer.sv
// Time-multiplex slot counter, reusable by any TMUX stage.
// Ports:
//   clk_x  in   fast clock
//   rst_i  in   synchronous active-high reset
//   en_i   in   enable; counter is held at 0 while low
//   tick_o out  combinational, high in the last slot (cnt==TRATE-1) while enabled
//   cnt_o  out  current slot number, 0..TRATE-1
module tmux_sequencer #(
  parameter int TRATE = 12,
  parameter int TBITS = 4
) (
  input  logic             clk_x,
  input  logic             rst_i,
  input  logic             en_i,
  output logic             tick_o,
  output logic [TBITS-1:0] cnt_o
);

  localparam logic [TBITS-1:0] LAST = TBITS'(TRATE - 1);

  logic [TBITS-1:0] cnt_q, cnt_d;
  // en_q marks that en_i was already high on the previous edge. The first
  // enabled edge only aligns the counter to slot 0, so slot 0 lasts one full
  // cycle after the enabling edge and the first tick lands TRATE edges later.
  logic             en_q;

  always_comb begin
    cnt_d = '0;
    if (en_i && en_q) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_x) begin
    if (rst_i) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_i;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/tart_hilbert_tmux.sv
// Correlator front end: samples the raw antenna word once per TRATE fast
// cycles and forms a one-sample-delay Hilbert pair (re = current sample,
// im = previous sample), plus the valid/strobe timing for the correlators.
// Ports:
//   clk_x    in   fast correlator clock (TRATE x sample rate)
//   rst_i    in   synchronous active-high reset
//   en_i     in   acquisition enable (already in clk_x domain)
//   d_i      in   raw antenna word, stable across each TRATE window
//   valid_o  out  re_o/im_o valid; stays high through RUN
//   strobe_o out  one-cycle pulse with each new re_o/im_o pair (slot 0)
//   re_o     out  current sample
//   im_o     out  previous sample
//   tick_o   out  TMUX slot counter, debug only
module tart_hilbert_tmux
  import tart_hilbert_tmux_pkg::*;
#(
  parameter int WIDTH = NUM_ANTENNA,
  parameter int TRATE = TMUX_RATE,
  parameter int TB    = TBITS
) (
  input  logic             clk_x,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             valid_o,
  output logic             strobe_o,
  output logic [WIDTH-1:0] re_o,
  output logic [WIDTH-1:0] im_o,
  output logic [TB-1:0]    tick_o
);

  logic        tick;
  logic [TB-1:0] cnt;

  tmux_sequencer #(.TRATE(TRATE), .TBITS(TB)) u_seq (
    .clk_x  (clk_x),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .tick_o (tick),
    .cnt_o  (cnt)
  );

  tmux_state_e      state_q;
  logic             valid_q, strobe_q;
  logic [WIDTH-1:0] re_q, im_q;

  // Dropping en_i always forces a full re-prime, so im_q can never pair a
  // pre-drop sample with a post-drop one.
  always_ff @(posedge clk_x) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
    end else if (!en_i) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_q  <= 1'b0;
          strobe_q <= 1'b0;
          state_q  <= ST_PRIME;
        end
        ST_PRIME: begin
          strobe_q <= 1'b0;
          if (tick) begin
            re_q    <= d_i;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            im_q     <= re_q;
            re_q     <= d_i;
            strobe_q <= 1'b1;
            valid_q  <= 1'b1;
          end else begin
            strobe_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          valid_q  <= 1'b0;
          strobe_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o  = valid_q;
  assign strobe_o = strobe_q;
  assign re_o     = re_q;
  assign im_o     = im_q;
  assign tick_o   = cnt;

endmodule

// File: tb/tb_tart_hilbert_tmux.sv
module tb_tart_hilbert_tmux;

  localparam int W = 24;
  localparam int R = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [W-1:0]  din = '0;
  logic          valid_o, strobe_o;
  logic [W-1:0]  re_o, im_o;
  logic [3:0]    tick_o;

  tart_hilbert_tmux dut (
    .clk_x(clk), .rst_i(rst), .en_i(en), .d_i(din),
    .valid_o(valid_o), .strobe_o(strobe_o),
    .re_o(re_o), .im_o(im_o), .tick_o(tick_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: n counts consecutive enabled edges since the last
  // drop/reset. Samples are taken on enabled edges n = 13, 25, 37, ...
  // The first is the prime, every later one produces a strobe.
  int           n = 0;
  logic [W-1:0] m_re = '0, m_im = '0;
  logic         m_valid = 1'b0, m_strobe = 1'b0;
  logic [3:0]   m_tick = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic e, input logic [W-1:0] d);
    m_strobe = 1'b0;
    if (r) begin
      n = 0; m_re = '0; m_im = '0; m_valid = 1'b0;
    end else if (!e) begin
      n = 0; m_valid = 1'b0;
    end else begin
      n++;
      if (n > 1 && (n - 1) % R == 0) begin
        if (n == R + 1) m_re = d;
        else begin
          m_im = m_re; m_re = d; m_strobe = 1'b1; m_valid = 1'b1;
        end
      end
    end
    m_tick = (n == 0) ? 4'd0 : 4'((n - 1) % R);
  endtask

  task automatic step(input logic r, input logic e, input logic [W-1:0] d);
    @(negedge clk);
    rst = r; en = e; din = d;
    @(posedge clk);
    model(r, e, d);
    #1;
    chk("re",     32'(re_o),     32'(m_re));
    chk("im",     32'(im_o),     32'(m_im));
    chk("valid",  32'(valid_o),  32'(m_valid));
    chk("strobe", 32'(strobe_o), 32'(m_strobe));
    chk("tick",   32'(tick_o),   32'(m_tick));
  endtask

  initial begin
    int strobes, last, cyc;
    logic vok;
    logic [W-1:0] sre, sim;

    // 1: reset with enable high and all-ones data
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 24'hFFFFFF);
      chk("rst_re", 32'(re_o), 32'h0);
      chk("rst_valid", 32'(valid_o), 32'h0);
    end
    step(1'b0, 1'b0, 24'h0);

    // 2: prime and first pairs (first step here is edge k)
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 24'h000001);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 24'h000002);
    chk("pre_strobe", 32'(strobe_o), 32'h0);
    step(1'b0, 1'b1, 24'h000002);          // edge k+24
    chk("k24_re", 32'(re_o), 32'h000002);
    chk("k24_im", 32'(im_o), 32'h000001);
    chk("k24_strobe", 32'(strobe_o), 32'h1);
    chk("k24_valid", 32'(valid_o), 32'h1);
    step(1'b0, 1'b1, 24'h000003);          // edge k+25
    chk("k25_strobe", 32'(strobe_o), 32'h0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 24'h000003);
    chk("k36_re", 32'(re_o), 32'h000003);
    chk("k36_im", 32'(im_o), 32'h000002);

    // 3: steady run, 10 strobes 12 apart, valid never drops
    strobes = 0; last = 0; vok = 1'b1;
    for (int i = 1; i <= 120; i++) begin
      step(1'b0, 1'b1, 24'($urandom));
      if (!valid_o) vok = 1'b0;
      if (strobe_o) begin
        if (strobes > 0) chk("spacing", 32'(i - last), 32'd12);
        strobes++; last = i;
      end
    end
    chk("strobe_count", 32'(strobes), 32'd10);
    chk("valid_held", 32'(vok), 32'h1);

    // 4: drop enable on the tick cycle
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 24'($urandom));
    chk("cnt11", 32'(tick_o), 32'd11);
    sre = re_o; sim = im_o;
    step(1'b0, 1'b0, 24'h5A5A5A);
    chk("drop_strobe", 32'(strobe_o), 32'h0);
    chk("drop_valid", 32'(valid_o), 32'h0);
    chk("drop_re", 32'(re_o), 32'(sre));
    chk("drop_im", 32'(im_o), 32'(sim));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 24'($urandom));

    // 5: re-enable, full re-prime
    for (int i = 0; i <= 24; i++) begin
      step(1'b0, 1'b1, (i <= 12) ? 24'hABCDEF : 24'h123456);
      chk("reprime_strobe", 32'(strobe_o), 32'(i == 24));
    end
    chk("reprime_re", 32'(re_o), 32'h123456);
    chk("reprime_im", 32'(im_o), 32'hABCDEF);

    // 6: one-cycle reset mid-run
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 24'($urandom));
    step(1'b1, 1'b1, 24'($urandom));
    chk("mrst_re", 32'(re_o), 32'h0);
    chk("mrst_im", 32'(im_o), 32'h0);
    chk("mrst_valid", 32'(valid_o), 32'h0);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b1, 24'($urandom));
      chk("mrst_strobe", 32'(strobe_o), 32'(i == 24));
    end

    // random soak against the model
    cyc = 0;
    repeat (800) begin
      step(($urandom % 150) == 0, ($urandom % 40) != 0, 24'($urandom));
      cyc++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
